// File: rtl/seq_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_onehot_decoder
// Purpose  : Parametrised binary-to-one-hot decoder with a registered,
//            handshaked output. It also has an auto-scan mode that walks the
//            single active line up or down, one step every STEP_DIV clocks.
//            It drives select/enable fan-out (channel strobes, LED scan,
//            bank enables) from a small control FSM.
// Macro    : SEQ_ONEHOT_DECODER_RANGE_ERR_EN
//              defined   -> an out-of-range LOAD/SCAN code sets sticky err
//              undefined -> err is held at 0
// Params   : IN_W     width of in_code
//            NUM_OUT  number of one-hot lines (2 <= NUM_OUT <= 2**IN_W)
//            STEP_DIV clocks per scan step (>= 1)
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            in_valid   command valid
//            in_ready   command accepted when in_valid & in_ready
//            in_mode    00 LOAD, 01 SCAN_UP, 10 SCAN_DOWN, 11 CLEAR
//            in_code    line index (start index for scans)
//            y          registered one-hot output, zero when idle
//            y_valid    y holds a valid pattern
//            y_ready    downstream consumed y (honoured in HOLD only)
//            scan_wrap  one-cycle pulse while the wrapped scan line is shown
//            err        sticky range error
// Revision : 1.0  initial release
// ============================================================================
module seq_onehot_decoder #(
  parameter int IN_W     = 3,
  parameter int NUM_OUT  = 8,
  parameter int STEP_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [IN_W-1:0]    in_code,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               scan_wrap,
  output logic               err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HOLD = 2'd1;
  localparam logic [1:0] c_ST_SCAN = 2'd2;

  localparam logic [1:0] c_MODE_LOAD  = 2'b00;
  localparam logic [1:0] c_MODE_DOWN  = 2'b10;
  localparam logic [1:0] c_MODE_CLEAR = 2'b11;

  localparam int                 c_DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);
  // One extra bit so that NUM_OUT == 2**IN_W is still representable.
  localparam logic [IN_W:0]      c_NUM      = (IN_W + 1)'(NUM_OUT);
  localparam logic [IN_W-1:0]    c_PTR_LAST = IN_W'(NUM_OUT - 1);

`ifdef SEQ_ONEHOT_DECODER_RANGE_ERR_EN
  localparam logic c_ERR_EN = 1'b1;
`else
  localparam logic c_ERR_EN = 1'b0;
`endif

  logic [1:0]         r_state;
  logic [NUM_OUT-1:0] r_y;
  logic               r_y_valid;
  logic               r_wrap;
  logic               r_err;
  logic [IN_W-1:0]    r_ptr;
  logic [c_DIV_W-1:0] r_div;
  logic               r_dir;       // 1 = scanning downwards

  logic [1:0]         w_state_nx;
  logic [NUM_OUT-1:0] w_y_nx;
  logic               w_valid_nx;
  logic               w_wrap_nx;
  logic [IN_W-1:0]    w_ptr_nx;
  logic [c_DIV_W-1:0] w_div_nx;
  logic               w_dir_nx;
  logic               w_err_set;
  logic               w_err_clr;

  logic               w_accept;
  logic               w_code_ok;
  logic [NUM_OUT-1:0] w_code_dec;
  logic [IN_W-1:0]    w_ptr_step;
  logic               w_step_wrap;
  logic [NUM_OUT-1:0] w_step_dec;

  // Index-compare decoder: an index outside 0..NUM_OUT-1 yields all zeros,
  // so no nonexistent or multiple lines can ever be driven.
  function automatic logic [NUM_OUT-1:0] f_dec(input logic [IN_W-1:0] idx);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = (idx == IN_W'(i));
    end
    return v;
  endfunction

  assign in_ready  = (r_state != c_ST_HOLD) | y_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_code_ok = ({1'b0, in_code} < c_NUM);
  assign w_code_dec = f_dec(in_code);

  // Next scan position; wrap is measured against NUM_OUT, not 2**IN_W.
  always_comb begin
    w_ptr_step  = r_ptr;
    w_step_wrap = 1'b0;
    if (r_dir) begin
      if (r_ptr == '0) begin
        w_ptr_step  = c_PTR_LAST;
        w_step_wrap = 1'b1;
      end else begin
        w_ptr_step  = r_ptr - 1'b1;
      end
    end else begin
      if (r_ptr == c_PTR_LAST) begin
        w_ptr_step  = '0;
        w_step_wrap = 1'b1;
      end else begin
        w_ptr_step  = r_ptr + 1'b1;
      end
    end
  end

  assign w_step_dec = f_dec(w_ptr_step);

  always_comb begin
    w_state_nx = r_state;
    w_y_nx     = r_y;
    w_valid_nx = r_y_valid;
    w_wrap_nx  = 1'b0;
    w_ptr_nx   = r_ptr;
    w_div_nx   = r_div;
    w_dir_nx   = r_dir;
    w_err_set  = 1'b0;
    w_err_clr  = 1'b0;

    if (w_accept) begin
      // An accepted command always wins over a coincident scan step.
      if (in_mode == c_MODE_CLEAR) begin
        w_state_nx = c_ST_IDLE;
        w_y_nx     = '0;
        w_valid_nx = 1'b0;
        w_ptr_nx   = '0;
        w_div_nx   = '0;
        w_err_clr  = 1'b1;
      end else if (!w_code_ok) begin
        w_state_nx = c_ST_IDLE;
        w_y_nx     = '0;
        w_valid_nx = 1'b0;
        w_div_nx   = '0;
        w_err_set  = 1'b1;
      end else if (in_mode == c_MODE_LOAD) begin
        w_state_nx = c_ST_HOLD;
        w_y_nx     = w_code_dec;
        w_valid_nx = 1'b1;
      end else begin
        w_state_nx = c_ST_SCAN;
        w_y_nx     = w_code_dec;
        w_valid_nx = 1'b1;
        w_ptr_nx   = in_code;
        w_div_nx   = '0;
        w_dir_nx   = (in_mode == c_MODE_DOWN);
      end
    end else begin
      case (r_state)
        c_ST_IDLE: ;
        c_ST_HOLD: begin
          if (y_ready) begin
            w_state_nx = c_ST_IDLE;
            w_y_nx     = '0;
            w_valid_nx = 1'b0;
          end
        end
        c_ST_SCAN: begin
          if (r_div == c_DIV_LAST) begin
            w_div_nx  = '0;
            w_ptr_nx  = w_ptr_step;
            w_y_nx    = w_step_dec;
            w_wrap_nx = w_step_wrap;
          end else begin
            w_div_nx  = r_div + 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          w_state_nx = c_ST_IDLE;
          w_y_nx     = '0;
          w_valid_nx = 1'b0;
          w_ptr_nx   = '0;
          w_div_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_wrap    <= 1'b0;
      r_ptr     <= '0;
      r_div     <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_y       <= w_y_nx;
      r_y_valid <= w_valid_nx;
      r_wrap    <= w_wrap_nx;
      r_ptr     <= w_ptr_nx;
      r_div     <= w_div_nx;
      r_dir     <= w_dir_nx;
    end
  end

  // With the range-error feature disabled the set term is constant 0,
  // so r_err never leaves its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set & c_ERR_EN) begin
      r_err <= 1'b1;
    end
  end

  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign scan_wrap = r_wrap;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_onehot_decoder
// Purpose  : Self-checking bench for seq_onehot_decoder. Two instances share
//            the stimulus: inst 0 (IN_W=3, NUM_OUT=8, STEP_DIV=4) and
//            inst 1 (IN_W=3, NUM_OUT=5, STEP_DIV=1). A behavioural model
//            derives the scan position arithmetically from the start index
//            and the number of clocks elapsed since the scan began.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_onehot_decoder;

  localparam logic [1:0] LOAD = 2'b00, SUP = 2'b01, SDN = 2'b10, CLR = 2'b11;
  localparam int M_IDLE = 0, M_HOLD = 1, M_SCAN = 2;
`ifdef SEQ_ONEHOT_DECODER_RANGE_ERR_EN
  localparam logic c_ERR = 1'b1;
`else
  localparam logic c_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_mode = 2'b00;
  logic [2:0] in_code = 3'd0;
  logic       y_ready = 1'b0;

  logic       rdy0, yv0, wr0, er0;
  logic [7:0] y8;
  logic       rdy1, yv1, wr1, er1;
  logic [4:0] y5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_onehot_decoder #(.IN_W(3), .NUM_OUT(8), .STEP_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_mode(in_mode), .in_code(in_code), .y(y8), .y_valid(yv0),
    .y_ready(y_ready), .scan_wrap(wr0), .err(er0));

  seq_onehot_decoder #(.IN_W(3), .NUM_OUT(5), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_mode(in_mode), .in_code(in_code), .y(y5), .y_valid(yv1),
    .y_ready(y_ready), .scan_wrap(wr1), .err(er1));

  // ---------------- behavioural model ----------------
  int  m_mode[2];
  int  m_idx[2];
  int  m_dir[2];    // +1 up, -1 down
  int  m_k[2];      // clocks elapsed since the scan start pattern appeared
  bit  m_err[2];
  bit  m_live = 1'b0;

  function automatic int num_of(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int cur_line(input int i);
    int n, steps;
    n     = num_of(i);
    steps = (m_k[i] / div_of(i)) % n;
    if (m_dir[i] > 0) return (m_idx[i] + steps) % n;
    return (m_idx[i] - steps + n) % n;
  endfunction

  function automatic logic [7:0] exp_y(input int i);
    logic [7:0] one;
    one = 8'd1;
    if (m_mode[i] == M_HOLD) return one << m_idx[i];
    if (m_mode[i] == M_SCAN) return one << cur_line(i);
    return 8'd0;
  endfunction

  function automatic logic exp_wrap(input int i);
    if (m_mode[i] != M_SCAN || m_k[i] == 0 || (m_k[i] % div_of(i)) != 0) return 1'b0;
    if (m_dir[i] > 0) return cur_line(i) == 0;
    return cur_line(i) == num_of(i) - 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = M_IDLE;
        m_err[i]  = 1'b0;
      end else if (in_valid && (m_mode[i] != M_HOLD || y_ready)) begin
        if (in_mode == CLR) begin
          m_mode[i] = M_IDLE;
          m_err[i]  = 1'b0;
        end else if (int'(in_code) >= num_of(i)) begin
          m_mode[i] = M_IDLE;
          if (c_ERR) m_err[i] = 1'b1;
        end else begin
          m_idx[i]  = int'(in_code);
          m_mode[i] = (in_mode == LOAD) ? M_HOLD : M_SCAN;
          m_dir[i]  = (in_mode == SDN) ? -1 : 1;
          m_k[i]    = 0;
        end
      end else if (m_mode[i] == M_HOLD && y_ready) begin
        m_mode[i] = M_IDLE;
      end else if (m_mode[i] == M_SCAN) begin
        m_k[i] = m_k[i] + 1;
      end
    end
    if (rst) m_live = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [7:0] yy, input logic v,
                          input logic w, input logic e, input logic r);
    chk($sformatf("model_y%0d", i), {24'd0, yy}, {24'd0, exp_y(i)});
    chk($sformatf("model_yv%0d", i), {31'd0, v}, {31'd0, m_mode[i] != M_IDLE});
    chk($sformatf("model_wrap%0d", i), {31'd0, w}, {31'd0, exp_wrap(i)});
    chk($sformatf("model_err%0d", i), {31'd0, e}, {31'd0, m_err[i]});
    chk($sformatf("model_rdy%0d", i), {31'd0, r},
        {31'd0, (m_mode[i] != M_HOLD) || y_ready});
    chk($sformatf("onehot0_%0d", i), {31'd0, $onehot0(yy)}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      cmp_inst(0, y8, yv0, wr0, er0, rdy0);
      cmp_inst(1, {3'd0, y5}, yv1, wr1, er1, rdy1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] m, input logic [2:0] c);
    in_valid = 1'b1;
    in_mode  = m;
    in_code  = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset, LOAD with held back-pressure, then release
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_y", {24'd0, y8}, 32'h0);
    chk("rst_yv", {31'd0, yv0}, 32'd0);
    chk("rst_wrap", {31'd0, wr0}, 32'd0);
    chk("rst_err", {31'd0, er0}, 32'd0);
    chk("rst_rdy", {31'd0, rdy0}, 32'd1);
    cmd(LOAD, 3'd5);
    chk("load5_y", {24'd0, y8}, 32'h20);
    chk("load5_yv", {31'd0, yv0}, 32'd1);
    chk("load5_rdy", {31'd0, rdy0}, 32'd0);
    repeat (10) tick();
    chk("load5_hold_y", {24'd0, y8}, 32'h20);
    chk("load5_hold_rdy", {31'd0, rdy0}, 32'd0);
    y_ready = 1'b1;
    tick();
    chk("load5_rel_y", {24'd0, y8}, 32'h0);
    chk("load5_rel_yv", {31'd0, yv0}, 32'd0);
    chk("load5_rel_rdy", {31'd0, rdy0}, 32'd1);

    // 2: back-to-back LOAD with no idle bubble
    y_ready = 1'b0;
    cmd(LOAD, 3'd1);
    chk("load1_y", {24'd0, y8}, 32'h02);
    y_ready = 1'b1;
    cmd(LOAD, 3'd3);
    chk("b2b_y", {24'd0, y8}, 32'h08);
    chk("b2b_yv", {31'd0, yv0}, 32'd1);
    tick();
    y_ready = 1'b0;

    // 3: scans with wrap (inst 0: STEP_DIV=4)
    cmd(SUP, 3'd6);
    chk("sup_k0", {24'd0, y8}, 32'h40);
    repeat (3) tick();
    chk("sup_k3", {24'd0, y8}, 32'h40);
    tick();
    chk("sup_k4", {24'd0, y8}, 32'h80);
    repeat (4) tick();
    chk("sup_k8_y", {24'd0, y8}, 32'h01);
    chk("sup_k8_wrap", {31'd0, wr0}, 32'd1);
    tick();
    chk("sup_k9_y", {24'd0, y8}, 32'h01);
    chk("sup_k9_wrap", {31'd0, wr0}, 32'd0);
    repeat (3) tick();
    chk("sup_k12", {24'd0, y8}, 32'h02);
    cmd(SDN, 3'd0);
    chk("sdn_k0", {24'd0, y8}, 32'h01);
    repeat (4) tick();
    chk("sdn_k4_y", {24'd0, y8}, 32'h80);
    chk("sdn_k4_wrap", {31'd0, wr0}, 32'd1);

    // 4: NUM_OUT=5 instance, out-of-range and wrap at NUM_OUT
    cmd(CLR, 3'd0);
    y_ready = 1'b1;
    cmd(LOAD, 3'd6);
    chk("oor_y5", {27'd0, y5}, 32'h0);
    chk("oor_yv5", {31'd0, yv1}, 32'd0);
    chk("oor_err5", {31'd0, er1}, {31'd0, c_ERR});
    cmd(SUP, 3'd4);
    chk("n5_y", {27'd0, y5}, 32'h10);
    y_ready = 1'b0;
    tick();
    chk("n5_wrap_y", {27'd0, y5}, 32'h01);
    chk("n5_wrap", {31'd0, wr1}, 32'd1);

    // 5: CLEAR on a step-due cycle, then reset mid-scan
    repeat (1) tick();
    chk("pre_clr_y", {24'd0, y8}, 32'h10);
    cmd(CLR, 3'd5);
    chk("clr_y", {24'd0, y8}, 32'h0);
    chk("clr_yv", {31'd0, yv0}, 32'd0);
    chk("clr_wrap", {31'd0, wr0}, 32'd0);
    chk("clr_err", {31'd0, er0}, 32'd0);
    chk("clr_err5", {31'd0, er1}, 32'd0);
    cmd(SUP, 3'd2);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_y", {24'd0, y8}, 32'h0);
    chk("mid_rst_yv", {31'd0, yv0}, 32'd0);
    chk("mid_rst_wrap", {31'd0, wr0}, 32'd0);
    chk("mid_rst_y5", {27'd0, y5}, 32'h0);
    rst = 1'b0;

    // 6: random commands and back-pressure, checked by the model every cycle
    repeat (3000) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_mode  = ($urandom_range(0, 7) == 0) ? CLR : 2'($urandom_range(0, 2));
      in_code  = 3'($urandom_range(0, 7));
      y_ready  = ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
